// File: rtl/div_stage.sv
// div_stage: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU behind a valid/allow handshake.
// Optional build macro DIV_ZERO_FAST_EN: divide-by-zero skips iteration and raises div_by_zero.
module div_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_in,
  output logic             allow_in,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             valid_out,
  input  logic             allow_out,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
`ifdef DIV_ZERO_FAST_EN
  output logic             div_by_zero,
`endif
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] dvd_q;    // dividend magnitude, shifted out MSB-first; collects quotient bits
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rmd_q;
  logic             q_neg_q;
  logic             r_neg_q;
`ifdef DIV_ZERO_FAST_EN
  logic             dbz_q;
`endif

  logic             accept;
  logic             dvd_neg;
  logic             dvs_neg;
  logic             dvs_zero;
  logic [WIDTH-1:0] dvd_load;
  logic [WIDTH-1:0] dvs_load;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    allow_in = flush | (state_q == StIdle) | ((state_q == StDone) & allow_out);
    accept   = valid_in & allow_in & ~flush;

    dvd_neg  = in_signed & in_dividend[WIDTH-1];
    dvs_neg  = in_signed & in_divisor[WIDTH-1];
    dvs_zero = (in_divisor == '0);
    // A zero divisor keeps the raw dividend so the remainder comes out unmodified.
    dvd_load = (dvd_neg & ~dvs_zero) ? (~in_dividend + 1'b1) : in_dividend;
    dvs_load = dvs_neg ? (~in_divisor + 1'b1) : in_divisor;

    shifted  = {rem_q, dvd_q[WIDTH-1]};
    fits     = (shifted >= {1'b0, dvs_q});
    // When the trial fits the result is below the divisor, so WIDTH bits suffice.
    rem_nxt  = fits ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
    quo_nxt  = {dvd_q[WIDTH-2:0], fits};
    quo_fix  = q_neg_q ? (~quo_nxt + 1'b1) : quo_nxt;
    rem_fix  = r_neg_q ? (~rem_nxt + 1'b1) : rem_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
      dbz_q   <= 1'b0;
`endif
    end else if (flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else if (accept) begin
      dvd_q   <= dvd_load;
      dvs_q   <= dvs_load;
      rem_q   <= '0;
      q_neg_q <= ~dvs_zero & (dvd_neg ^ dvs_neg);
      r_neg_q <= ~dvs_zero & dvd_neg;
      cnt_q   <= CntW'(WIDTH - 1);
      state_q <= StCalc;
`ifdef DIV_ZERO_FAST_EN
      dbz_q   <= dvs_zero;
      if (dvs_zero) begin
        state_q <= StDone;
        cnt_q   <= '0;
        quo_q   <= '1;
        rmd_q   <= in_dividend;
      end
`endif
    end else begin
      unique case (state_q)
        StCalc: begin
          rem_q <= rem_nxt;
          dvd_q <= quo_nxt;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= StDone;
            quo_q   <= quo_fix;
            rmd_q   <= rem_fix;
          end
        end
        StDone: begin
          if (allow_out) begin
            state_q <= StIdle;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_out   = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
`ifdef DIV_ZERO_FAST_EN
  assign div_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_div_stage.sv
// tb_div_stage: directed vectors for div_stage with a queue scoreboard and a decoupled monitor.
module tb_div_stage;

  localparam int unsigned W = 32;
`ifdef DIV_ZERO_FAST_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, flush, valid_in, allow_in, in_signed, valid_out, allow_out, busy;
  logic [W-1:0] in_dividend, in_divisor, quotient, remainder;
`ifdef DIV_ZERO_FAST_EN
  logic         div_by_zero;
`endif

  div_stage #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .valid_in    (valid_in),
    .allow_in    (allow_in),
    .in_signed   (in_signed),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .valid_out   (valid_out),
    .allow_out   (allow_out),
    .quotient    (quotient),
    .remainder   (remainder),
`ifdef DIV_ZERO_FAST_EN
    .div_by_zero (div_by_zero),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           acc;
    int           lat;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a new result appears when valid_out rises or follows a completed handshake.
  logic prev_v = 1'b0, prev_hs = 1'b0;
  int   rise = 0;
  exp_t e;
  always @(negedge clk) begin
    if (reset) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (valid_out && (!prev_v || prev_hs)) begin
        rise = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious: got valid_out=1 expected no result pending (cycle %0d)", cyc);
        end
      end
      if (valid_out && allow_out && sb.size() > 0) begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("latency", W'(rise - e.acc), W'(e.lat));
`ifdef DIV_ZERO_FAST_EN
        chk("div_by_zero", W'(div_by_zero), W'(e.dbz));
`endif
      end
      prev_v  = valid_out;
      prev_hs = valid_out && allow_out;
    end
  end

  // Entered and left one time unit after a rising edge.
  task automatic issue(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input bit push);
    exp_t x;
    valid_in    = 1'b1;
    in_signed   = sg;
    in_dividend = a;
    in_divisor  = b;
    x.q   = eq;
    x.r   = er;
    x.acc = cyc + 1;
    // Edges from the accept edge to the first cycle showing valid_out.
    x.lat = (Fast && b == '0) ? 0 : W;
    x.dbz = (b == '0);
    if (push) sb.push_back(x);
    @(negedge clk);
    chk("allow_in_at_accept", W'(allow_in), W'(1));
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    chk("busy_after_accept", W'(busy), W'(1));
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    @(negedge clk);
    while (!valid_out && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("valid_wait", W'(valid_out), W'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; valid_in = 1'b0; allow_out = 1'b1;
    in_signed = 1'b0; in_dividend = '0; in_divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_out", W'(valid_out), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_allow_in", W'(allow_in), W'(1));
    chk("rst_quotient", quotient, '0);
    chk("rst_remainder", remainder, '0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors: signed, dividend, divisor, quotient, remainder
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);                  wait_drain(60);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1); wait_drain(60);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b1);     wait_drain(60);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1); wait_drain(60);
    issue(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);             wait_drain(60);
    issue(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1); wait_drain(60);
    issue(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b1); wait_drain(60);
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b1); wait_drain(60);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);     wait_drain(60);
    issue(1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b1);                    wait_drain(60);

    // Backpressure: result held for 10 cycles, then consumed alongside a new accept.
    allow_out = 1'b0;
    issue(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b1);
    wait_valid(60);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", W'(valid_out), W'(1));
      chk("hold_allow_in", W'(allow_in), W'(0));
      chk("hold_quotient", quotient, 32'd333);
      chk("hold_remainder", remainder, 32'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    allow_out = 1'b1;
    issue(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b1);
    wait_drain(60);

    // Flush at iteration 10 with a competing input offered.
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    valid_in = 1'b1;
    in_dividend = 32'd50;
    in_divisor = 32'd5;
    @(negedge clk);
    chk("flush_allow_in", W'(allow_in), W'(1));
    @(posedge clk);
    #1;
    flush = 1'b0;
    valid_in = 1'b0;
    chk("flush_valid_out", W'(valid_out), W'(0));
    chk("flush_busy", W'(busy), W'(0));
    chk("flush_allow_in_after", W'(allow_in), W'(1));
    repeat (W + 4) @(posedge clk);
    #1;
    chk("flush_no_start_busy", W'(busy), W'(0));
    chk("flush_no_start_valid", W'(valid_out), W'(0));

    // Reset while a result waits in DONE.
    allow_out = 1'b0;
    issue(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b1);
    wait_valid(60);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    chk("rst_done_valid_out", W'(valid_out), W'(0));
    chk("rst_done_allow_in", W'(allow_in), W'(1));
    chk("rst_done_quotient", quotient, '0);
    chk("rst_done_remainder", remainder, '0);
    allow_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    issue(1'b0, 32'd81, 32'd9, 32'd9, 32'd0, 1'b1);
    wait_drain(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
